// File: rtl/countdown_bcd_display_if.sv
// Control/status bundle between the phase FSM and one countdown display instance.
interface countdown_bcd_display_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 2
);
  logic                  load;
  logic [WIDTH-1:0]      load_val;
  logic                  tick;
  logic                  half_tick;
  logic                  hold;
  logic                  busy;
  logic                  running;
  logic [WIDTH-1:0]      remaining;
  logic [4*DIGITS-1:0]   digits;
  logic                  flicker;
  logic                  blink;
  logic                  expired;

  modport master (
    output load, load_val, tick, half_tick, hold,
    input  busy, running, remaining, digits, flicker, blink, expired
  );

  modport slave (
    input  load, load_val, tick, half_tick, hold,
    output busy, running, remaining, digits, flicker, blink, expired
  );
endinterface

// File: rtl/countdown_bcd_display.sv
// Phase-duration countdown: serial binary-to-BCD load, 1 Hz decrement with a parallel
// BCD borrow chain, leading-zero blanking, flicker/blink window and an expiry pulse.
//
// state | meaning
// IDLE  | no countdown active; digits show 0
// CONV  | double-dabble conversion of the captured value, one bit per cycle
// RUN   | counting down on tick (suppressed by hold)
module countdown_bcd_display #(
  parameter int WIDTH        = 8,
  parameter int DIGITS       = 2,
  parameter int FLICK_THRESH = 5,
  parameter int BLANK_LZ     = 1
) (
  input logic                     clk,
  input logic                     rst_n,
  countdown_bcd_display_if.slave  bus
);
  localparam int BW   = 4 * DIGITS;
  localparam int MAXV = 10 ** DIGITS - 1;
  localparam int CW   = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CONV, RUN} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  rem_q, rem_d, cap_q, cap_d, sh_q, sh_d, load_sat;
  logic [BW-1:0]     acc_q, acc_d, bcd_q, bcd_d, dig_q, dig_d, acc_step;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              pend_q, pend_d, busy_q, busy_d, run_q, run_d;
  logic              flick_q, flick_d, blink_q, blink_d, exp_q, exp_d;
  logic              dec;

  function automatic logic [BW-1:0] dd_step(input logic [BW-1:0] a, input logic b);
    logic [BW-1:0] t;
    t = a;
    for (int i = 0; i < DIGITS; i++)
      if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
    return {t[BW-2:0], b};
  endfunction

  // Ripple borrow from the ones digit upward; a 0 digit wraps to 9 and keeps borrowing.
  function automatic logic [BW-1:0] bcd_decr(input logic [BW-1:0] a);
    logic [BW-1:0] r;
    logic          borrow;
    r      = a;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] blank(input logic [BW-1:0] a);
    logic [BW-1:0] r;
    logic          lead;
    r    = a;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && a[4*i +: 4] == 4'd0) begin
        if (BLANK_LZ != 0) r[4*i +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
    return r;
  endfunction

  always_comb begin
    if (64'(bus.load_val) > 64'(MAXV)) load_sat = WIDTH'(MAXV);
    else                               load_sat = bus.load_val;
  end

  assign acc_step = dd_step(acc_q, sh_q[WIDTH-1]);
  assign dec      = (state_q == RUN) && (bus.tick || pend_q) && !bus.hold;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cap_d   = cap_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    busy_d  = busy_q;
    run_d   = run_q;
    exp_d   = 1'b0;
    if (bus.load) begin
      // a tick coinciding with load is deliberately lost
      state_d = CONV;
      cap_d   = load_sat;
      sh_d    = load_sat;
      acc_d   = '0;
      cnt_d   = '0;
      pend_d  = 1'b0;
      busy_d  = 1'b1;
      run_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        CONV: begin
          acc_d = acc_step;
          sh_d  = sh_q << 1;
          cnt_d = cnt_q + 1'b1;
          if (bus.tick) pend_d = 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            busy_d = 1'b0;
            bcd_d  = acc_step;
            rem_d  = cap_q;
            if (cap_q == '0) begin
              state_d = IDLE;
              exp_d   = 1'b1;
              pend_d  = 1'b0;
            end else begin
              state_d = RUN;
              run_d   = 1'b1;
            end
          end
        end
        RUN: begin
          if (dec) begin
            rem_d  = rem_q - 1'b1;
            bcd_d  = bcd_decr(bcd_q);
            pend_d = 1'b0;
            if (rem_q == WIDTH'(1)) begin
              state_d = IDLE;
              run_d   = 1'b0;
              exp_d   = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    dig_d   = blank(bcd_d);
    flick_d = run_d && (rem_d != '0) && (64'(rem_d) < 64'(FLICK_THRESH));
    // blink starts lit on the cycle the flicker window opens
    blink_d = (flick_d && flick_q) ? (blink_q ^ bus.half_tick) : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      cap_q   <= '0;
      sh_q    <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
      dig_q   <= blank('0);
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      run_q   <= 1'b0;
      flick_q <= 1'b0;
      blink_q <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cap_q   <= cap_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      dig_q   <= dig_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      run_q   <= run_d;
      flick_q <= flick_d;
      blink_q <= blink_d;
      exp_q   <= exp_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.running   = run_q;
  assign bus.remaining = rem_q;
  assign bus.digits    = dig_q;
  assign bus.flicker   = flick_q;
  assign bus.blink     = blink_q;
  assign bus.expired   = exp_q;
endmodule
